// File: rtl/lcd_defs.sv
// lcd_defs: shared FSM/phase encodings, HD44780 command bytes and hex-to-ASCII helper
package lcd_defs;
  localparam int CNT_W = 24;
  typedef enum logic [2:0] {ST_POWERUP, ST_INIT_NIB, ST_INIT_CMD, ST_IDLE, ST_UPD} state_e;
  typedef enum logic [2:0] {PH_IDLE, PH_SETUP, PH_PULSE, PH_GAP, PH_WAIT} phase_e;
  localparam logic [7:0] LCD_FUNC_SET = 8'h28;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_ADDR0    = 8'h80;
  function automatic logic [7:0] hex_to_ascii(input logic [3:0] n);
    return n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction
endpackage

// File: rtl/lcd_result_display_nibble_writer.sv
// lcd_nibble_writer: drives one nibble as setup / E pulse / gap, then the post-command wait
// when the nibble is flagged as the last of a command.
module lcd_nibble_writer
  import lcd_defs::*;
#(
  parameter int E_PULSE    = 12,
  parameter int NIBBLE_GAP = 50
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             iStart,
  input  logic             iRS,
  input  logic             iLast,
  input  logic [3:0]       iNibble,
  input  logic [CNT_W-1:0] iWait,
  output logic             oDone,
  output logic             oFree,
  output logic             oE,
  output logic             oRS,
  output logic [3:0]       oData
);
  phase_e ph_q, ph_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, wait_q, wait_d;
  logic last_q, last_d, rs_q, rs_d, expire;
  logic [3:0] nib_q, nib_d;
  // oDone marks the final cycle, so a start issued then lands with no bubble
  always_comb begin
    expire = cnt_q == '0;
    oDone  = expire && ((ph_q == PH_GAP && (!last_q || wait_q == '0)) || ph_q == PH_WAIT);
    oFree  = ph_q == PH_IDLE || oDone;
    ph_d   = ph_q;
    cnt_d  = expire ? cnt_q : cnt_q - 1'b1;
    wait_d = wait_q;
    last_d = last_q;
    rs_d   = rs_q;
    nib_d  = nib_q;
    if (iStart && oFree) begin
      ph_d   = PH_SETUP;
      cnt_d  = '0;
      wait_d = iWait;
      last_d = iLast;
      rs_d   = iRS;
      nib_d  = iNibble;
    end else if (expire) begin
      case (ph_q)
        PH_SETUP: begin ph_d = PH_PULSE; cnt_d = CNT_W'(E_PULSE - 1); end
        PH_PULSE: begin ph_d = PH_GAP;   cnt_d = CNT_W'(NIBBLE_GAP - 1); end
        PH_GAP:   begin ph_d = oDone ? PH_IDLE : PH_WAIT; cnt_d = wait_q - 1'b1; end
        default:  ph_d = PH_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q   <= PH_IDLE;
      cnt_q  <= '0;
      wait_q <= '0;
      last_q <= 1'b0;
      rs_q   <= 1'b0;
      nib_q  <= '0;
    end else begin
      ph_q   <= ph_d;
      cnt_q  <= cnt_d;
      wait_q <= wait_d;
      last_q <= last_d;
      rs_q   <= rs_d;
      nib_q  <= nib_d;
    end
  end
  assign oE    = ph_q == PH_PULSE;
  assign oRS   = rs_q;
  assign oData = nib_q;
endmodule

// File: rtl/lcd_result_display.sv
// lcd_result_display: HD44780 4-bit init sequencer plus valid/ready update of an 8-bit value
// shown as two hex ASCII characters at DDRAM address 0.
module lcd_result_display
  import lcd_defs::*;
#(
  parameter int POWERUP_CYCLES = 750000,
  parameter int INIT_WAIT1     = 205000,
  parameter int INIT_WAIT2     = 5000,
  parameter int E_PULSE        = 12,
  parameter int NIBBLE_GAP     = 50,
  parameter int CMD_WAIT       = 2000,
  parameter int CLEAR_WAIT     = 82000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] iData,
  input  logic       iValid,
  output logic       oReady,
  output logic       oLCD_E,
  output logic       oLCD_RS,
  output logic       oLCD_RW,
  output logic [3:0] oLCD_Data
);
  localparam logic [CNT_W-1:0] W_CMD   = CNT_W'(CMD_WAIT);
  localparam logic [CNT_W-1:0] W_CLEAR = CNT_W'(CLEAR_WAIT);
  localparam logic [CNT_W-1:0] W_INIT1 = CNT_W'(INIT_WAIT1);
  localparam logic [CNT_W-1:0] W_INIT2 = CNT_W'(INIT_WAIT2);
  // leaving POWERUP one edge early lets the first setup cycle start exactly POWERUP_CYCLES in
  localparam logic [CNT_W-1:0] PWR_END = CNT_W'(POWERUP_CYCLES - 2);
  state_e st_q, st_d;
  logic [CNT_W-1:0] pwr_q, pwr_d, wt;
  logic [3:0] idx_q, idx_d, len, nib;
  logic [7:0] data_q, data_d, byte_v;
  logic sending, go, fin, free, done, rs, last;
  always_comb begin
    sending = st_q inside {ST_INIT_NIB, ST_INIT_CMD, ST_UPD};
    len     = st_q == ST_INIT_NIB ? 4'd4 : st_q == ST_INIT_CMD ? 4'd8 : 4'd6;
    byte_v  = st_q == ST_INIT_NIB ? (idx_q == 4'd3 ? 8'h20 : 8'h30)
            : st_q == ST_INIT_CMD ? (idx_q[2:1] == 2'd0 ? LCD_FUNC_SET
                                   : idx_q[2:1] == 2'd1 ? LCD_ENTRY
                                   : idx_q[2:1] == 2'd2 ? LCD_DISP_ON : LCD_CLEAR)
            : idx_q[2:1] == 2'd0 ? LCD_ADDR0
            : idx_q[2:1] == 2'd1 ? hex_to_ascii(data_q[7:4]) : hex_to_ascii(data_q[3:0]);
    last    = st_q == ST_INIT_NIB || idx_q[0];
    nib     = (idx_q[0] && st_q != ST_INIT_NIB) ? byte_v[3:0] : byte_v[7:4];
    rs      = st_q == ST_UPD && idx_q[2:1] != 2'd0;
    wt      = st_q == ST_INIT_NIB ? (idx_q == 4'd0 ? W_INIT1 : idx_q == 4'd1 ? W_INIT2 : W_CMD)
            : (st_q == ST_INIT_CMD && idx_q[2:1] == 2'd3) ? W_CLEAR : W_CMD;
    go      = sending && free && idx_q != len;
    fin     = sending && done && idx_q == len;
    st_d    = st_q == ST_POWERUP ? (pwr_q == PWR_END ? ST_INIT_NIB : ST_POWERUP)
            : st_q == ST_IDLE ? (iValid ? ST_UPD : ST_IDLE)
            : fin ? (st_q == ST_INIT_NIB ? ST_INIT_CMD : ST_IDLE) : st_q;
    idx_d   = go ? idx_q + 1'b1 : (fin || st_q == ST_IDLE) ? 4'd0 : idx_q;
    pwr_d   = st_q == ST_POWERUP ? pwr_q + 1'b1 : pwr_q;
    data_d  = oReady && iValid ? iData : data_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= ST_POWERUP;
      pwr_q  <= '0;
      idx_q  <= '0;
      data_q <= '0;
    end else begin
      st_q   <= st_d;
      pwr_q  <= pwr_d;
      idx_q  <= idx_d;
      data_q <= data_d;
    end
  end
  lcd_nibble_writer #(.E_PULSE(E_PULSE), .NIBBLE_GAP(NIBBLE_GAP)) u_wr (
    .clk    (clk),
    .rst_n  (rst_n),
    .iStart (go),
    .iRS    (rs),
    .iLast  (last),
    .iNibble(nib),
    .iWait  (wt),
    .oDone  (done),
    .oFree  (free),
    .oE     (oLCD_E),
    .oRS    (oLCD_RS),
    .oData  (oLCD_Data)
  );
  assign oReady  = st_q == ST_IDLE;
  assign oLCD_RW = 1'b0;
endmodule

// File: tb/tb_lcd_result_display.sv
// tb_lcd_result_display: directed checks of init sequence, update bytes, handshake timing and reset.
module tb_lcd_result_display;
  logic clk = 1'b0, rst_n = 1'b0, iValid = 1'b0;
  logic [7:0] iData = 8'h00;
  logic oReady, oLCD_E, oLCD_RS, oLCD_RW;
  logic [3:0] oLCD_Data;
  int checks = 0, errors = 0, cyc = 0;
  logic [4:0] nibs[$];
  logic [4:0] exp_q[$];
  int rises[$];
  logic pe = 1'b0, prs = 1'b0;
  logic [3:0] pd = 4'h0;

  lcd_result_display #(
    .POWERUP_CYCLES(50), .INIT_WAIT1(40), .INIT_WAIT2(20), .E_PULSE(2),
    .NIBBLE_GAP(3), .CMD_WAIT(10), .CLEAR_WAIT(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .iData(iData), .iValid(iValid), .oReady(oReady),
    .oLCD_E(oLCD_E), .oLCD_RS(oLCD_RS), .oLCD_RW(oLCD_RW), .oLCD_Data(oLCD_Data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // record each nibble latched by the LCD and confirm RS/Data were already settled before E rose
  always @(negedge clk) begin
    if (oLCD_E && !pe) begin
      nibs.push_back({oLCD_RS, oLCD_Data});
      rises.push_back(cyc);
      chk("setup_stable", {27'd0, oLCD_RS, oLCD_Data}, {27'd0, prs, pd});
    end
    pe  = oLCD_E;
    prs = oLCD_RS;
    pd  = oLCD_Data;
  end

  task automatic wait_ready(input int bound, input string tag);
    int i = 0;
    while (!oReady && i < bound) begin
      @(negedge clk);
      i++;
    end
    chk(tag, oReady, 1);
  endtask

  task automatic check_nibs(input string tag, input int base);
    chk({tag, "_count"}, nibs.size() - base, exp_q.size());
    foreach (exp_q[i])
      chk(tag, (base + i < nibs.size()) ? nibs[base + i] : 5'bx, exp_q[i]);
  endtask

  task automatic set_upd(input logic [7:0] hi, input logic [7:0] lo);
    exp_q = '{5'h08, 5'h00, {1'b1, hi[7:4]}, {1'b1, hi[3:0]}, {1'b1, lo[7:4]}, {1'b1, lo[3:0]}};
  endtask

  task automatic xfer(input logic [7:0] d, output int k);
    iData  = d;
    iValid = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    iValid = 1'b0;
    chk("ready_drop", oReady, 0);
  endtask

  task automatic run_xfer(input string tag, input logic [7:0] d, input logic [7:0] hi, input logic [7:0] lo);
    int base, rb, k;
    base = nibs.size();
    rb = rises.size();
    xfer(d, k);
    wait_ready(200, {tag, "_ready"});
    chk({tag, "_lat"}, cyc - k, 67);
    chk({tag, "_e_rise"}, (rises.size() > rb) ? rises[rb] : -1, k + 2);
    set_upd(hi, lo);
    check_nibs(tag, base);
  endtask

  initial begin
    int base, rb, k, run, i;
    repeat (3) @(negedge clk);
    chk("rst_ready", oReady, 0);
    chk("rst_e", oLCD_E, 0);
    chk("rst_rs", oLCD_RS, 0);
    chk("rst_rw", oLCD_RW, 0);
    chk("rst_data", oLCD_Data, 0);
    rst_n = 1'b1;
    k = cyc;
    base = nibs.size();
    rb = rises.size();
    wait_ready(1000, "init_ready");
    exp_q = '{5'h03, 5'h03, 5'h03, 5'h02, 5'h02, 5'h08, 5'h00, 5'h06, 5'h00, 5'h0C, 5'h00, 5'h01};
    check_nibs("init", base);
    chk("powerup", (rises.size() > rb) ? rises[rb] : -1, k + 51);
    chk("clear_wait", cyc - rises[rises.size() - 1], 25);

    run_xfer("x5a", 8'h5A, 8'h35, 8'h41);
    run_xfer("xf0", 8'hF0, 8'h46, 8'h30);
    run_xfer("x09", 8'h09, 8'h30, 8'h39);

    // 0x34 is presented while busy and must wait for oReady
    base = nibs.size();
    xfer(8'h12, k);
    iData  = 8'h34;
    iValid = 1'b1;
    wait_ready(200, "busy_ready");
    set_upd(8'h31, 8'h32);
    check_nibs("busy12", base);
    base = nibs.size();
    k = cyc + 1;
    @(negedge clk);
    iValid = 1'b0;
    chk("busy_accept", oReady, 0);
    wait_ready(200, "x34_ready");
    chk("x34_lat", cyc - k, 67);
    set_upd(8'h33, 8'h34);
    check_nibs("x34", base);

    // continuous valid: exactly one ready cycle between updates
    base = nibs.size();
    iData  = 8'hAB;
    iValid = 1'b1;
    @(negedge clk);
    chk("b2b_first", oReady, 0);
    wait_ready(200, "b2b_ready");
    run = 0;
    while (oReady && run < 10) begin
      run++;
      @(negedge clk);
    end
    iValid = 1'b0;
    chk("b2b_run", run, 1);
    wait_ready(200, "b2b_done");
    exp_q = '{5'h08, 5'h00, 5'h14, 5'h11, 5'h14, 5'h12, 5'h08, 5'h00, 5'h14, 5'h11, 5'h14, 5'h12};
    check_nibs("b2b", base);

    // reset while E is high on the first nibble of the second update byte
    rb = rises.size();
    iData  = 8'h77;
    iValid = 1'b1;
    @(negedge clk);
    iValid = 1'b0;
    i = 0;
    while (rises.size() < rb + 3 && i < 100) begin
      @(negedge clk);
      i++;
    end
    chk("mid_e_high", oLCD_E, 1);
    chk("mid_rs_high", oLCD_RS, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_e", oLCD_E, 0);
    chk("mid_rst_rs", oLCD_RS, 0);
    chk("mid_rst_data", oLCD_Data, 0);
    chk("mid_rst_ready", oReady, 0);
    @(negedge clk);
    rst_n = 1'b1;
    k = cyc;
    base = nibs.size();
    rb = rises.size();
    wait_ready(1000, "reinit_ready");
    exp_q = '{5'h03, 5'h03, 5'h03, 5'h02, 5'h02, 5'h08, 5'h00, 5'h06, 5'h00, 5'h0C, 5'h00, 5'h01};
    check_nibs("reinit", base);
    chk("reinit_powerup", (rises.size() > rb) ? rises[rb] : -1, k + 51);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lcd_result_display.md
# lcd_result_display

Downstream display stage for the mini-ALU: takes the 8-bit result the ALU latches onto its LED register and shows it as two hexadecimal ASCII characters on an HD44780-compatible character LCD driven in 4-bit mode. It runs the LCD power-up initialisation, then accepts display values through a valid/ready handshake and writes each value to DDRAM address 0 (line 1, column 0). Write-only: the LCD busy flag is never read; all delays come from cycle counters.

## Interface
Parameters (cycle counts; reduce for simulation):
- POWERUP_CYCLES, 750000: wait after reset before the first LCD access (15 ms at 50 MHz).
- INIT_WAIT1, 205000: wait after the 1st 0x3 init nibble (4.1 ms).
- INIT_WAIT2, 5000: wait after the 2nd 0x3 init nibble (100 µs).
- E_PULSE, 12: number of cycles oLCD_E is held high per nibble.
- NIBBLE_GAP, 50: number of cycles oLCD_E is held low after each nibble.
- CMD_WAIT, 2000: wait after every byte except clear (40 µs).
- CLEAR_WAIT, 82000: wait after the clear command (1.64 ms).

Ports:
- Clock, input, 1: single clock; all logic is on the rising edge.
- Reset, input, 1: asynchronous, active-low reset.
- iData, input, 8: value to display (fed from the ALU LED register).
- iValid, input, 1: iData is valid.
- oReady, output, 1: block is idle and will accept on this edge.
- oLCD_E, output, 1: LCD enable strobe.
- oLCD_RS, output, 1: register select (0 = command, 1 = data).
- oLCD_RW, output, 1: tied to 0.
- oLCD_Data, output, 4: data nibble (DB7..DB4).

## Operation
- Reset values: oReady=0, oLCD_E=0, oLCD_RS=0, oLCD_RW=0, oLCD_Data=0. The FSM goes to POWERUP.
- FSM states: POWERUP → INIT_NIB (4 single-nibble writes) → INIT_CMD (4 bytes) → IDLE → UPD (3 bytes) → IDLE.
- Init nibbles, all RS=0:
  - 0x3, then wait INIT_WAIT1
  - 0x3, then wait INIT_WAIT2
  - 0x3, then wait CMD_WAIT
  - 0x2, then wait CMD_WAIT
- Init bytes, all RS=0:
  - 0x28, then wait CMD_WAIT
  - 0x06, then wait CMD_WAIT
  - 0x0C, then wait CMD_WAIT
  - 0x01, then wait CLEAR_WAIT
- IDLE: oReady=1. A handshake occurs when iValid && oReady are both high on a rising edge. On that edge iData is captured and oReady drops the following cycle.
- UPD sends three bytes:
  - 0x80 with RS=0
  - ASCII of iData[7:4] with RS=1
  - ASCII of iData[3:0] with RS=1
- Hex-to-ASCII mapping: n<10 → 0x30+n; n≥10 → 0x37+n (so 0xA → 0x41 'A').
- Bytes are sent high nibble first.
- iValid while oReady=0 is ignored (nothing is captured). The source must hold iValid until it sees oReady.
- If Reset is asserted at any point, including mid-nibble with E high, all outputs return to their reset values immediately and the full init sequence restarts. A pending value is discarded.

## Timing
- Nibble cost N = 1 + E_PULSE + NIBBLE_GAP cycles:
  - 1 setup cycle: RS and Data driven, E=0
  - E_PULSE cycles with E=1
  - NIBBLE_GAP cycles with E=0
- RS and Data stay stable from the setup cycle until the end of the gap.
- Byte cost = 2N + wait. The wait starts after the low-nibble gap.
- Handshake at edge k:
  - first setup cycle begins at edge k+1
  - oLCD_E first rises at edge k+2
  - oReady returns high exactly 1 + 3·(2N+CMD_WAIT) cycles after edge k
- Power-up: the first setup cycle starts POWERUP_CYCLES cycles after Reset deasserts.
- oReady first rises after the final CLEAR_WAIT expires.
- If iValid is high in the first cycle oReady=1, it is accepted on that edge. There is no extra bubble.

## Structure
- Package lcd_defs holds:
  - state enum
  - command constants: LCD_FUNC_SET=0x28, LCD_ENTRY=0x06, LCD_DISP_ON=0x0C, LCD_CLEAR=0x01, LCD_ADDR0=0x80
  - hex_to_ascii function
- Sub-module lcd_nibble_writer:
  - inputs: iStart, iRS, iNibble, iWait
  - outputs: oDone, E, RS, Data
  - owns the setup/pulse/gap/wait counter; iWait is applied only when flagged as the last nibble of a command
- The top-level FSM only sequences the nibble and byte lists.

## Test plan
Simulation parameters for all scenarios: POWERUP=50, INIT_WAIT1=40, INIT_WAIT2=20, E_PULSE=2, NIBBLE_GAP=3, CMD_WAIT=10, CLEAR_WAIT=20 (N=6).
- Reset release → nibbles on E rising edges are 3,3,3,2,2,8,0,6,0,C,0,1, all RS=0. oReady stays 0 until CLEAR_WAIT ends, then rises to 1.
- iData=0x5A accepted → nibbles 8,0 (RS=0), then 3,5,4,1 (RS=1). oReady high again 67 cycles after the handshake edge.
- iData=0xF0, then 0x09 → bytes 0x46,0x30, then 0x30,0x39. No nibble is skipped or duplicated.
- Accept 0x12, then drive iValid with 0x34 while busy → the display bytes remain 0x31,0x32. 0x34 is accepted only after oReady returns.
- Reset asserted while E=1 in the second UPD byte → E, RS, Data and oReady go to 0 in the same cycle. After release the full init is replayed.
- iValid held high continuously with 0xAB → back-to-back updates. oReady is high for exactly 1 cycle between them, and E never rises with RS/Data changing in the same cycle.
